// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, bit-time helper and frame-size constants.
// Frame length depends on UART_TX_PARITY_EN (adds one even-parity bit after D7).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

    // Truncating divide: the bit period is rounded down to a whole number of clocks.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered occupancy count; head entry is always visible on
// pop_data so the transmitter can load it on the same edge it pops.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser, or 8E1 when UART_TX_PARITY_EN is defined.
// Line outputs are registered from the FSM state, so o_Tx/o_Busy/o_Done trail the state by one clock.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Valid,
    input  logic [7:0]                    i_Data,
    output logic                          o_Ready,
    output logic                          o_Tx,
    output logic                          o_Busy,
    output logic                          o_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int TIMER_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         LAST_BIT   = 3'(DATA_BITS - 1);

    uart_state_t        state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [2:0]         bit_idx_reg;
    logic [7:0]         shift_reg;
    logic               tx_reg;
    logic               busy_reg;
    logic               done_reg;
`ifdef UART_TX_PARITY_EN
    logic               parity_reg;
`endif

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         fifo_head;
    logic               timer_last;

    assign fifo_push  = i_Valid && !fifo_full;
    assign fifo_pop   = (state_reg == ST_IDLE) && !fifo_empty;
    assign timer_last = (timer_reg == TIMER_LAST);

    assign o_Ready = !fifo_full;
    assign o_Tx    = tx_reg;
    assign o_Busy  = busy_reg;
    assign o_Done  = done_reg;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_Clk),
        .rst_n     (i_Rst),
        .push      (fifo_push),
        .push_data (i_Data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_Level)
    );

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            busy_reg <= (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg   <= fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_reg  <= ^fifo_head;
`endif
                        timer_reg   <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    tx_reg <= 1'b0;
                    if (timer_last) begin
                        timer_reg <= '0;
                        state_reg <= ST_DATA;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    // LSB is always on the line; shift once per completed bit period.
                    tx_reg <= shift_reg[0];
                    if (timer_last) begin
                        timer_reg <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx_reg <= parity_reg;
                    if (timer_last) begin
                        timer_reg <= '0;
                        state_reg <= ST_STOP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    tx_reg <= 1'b1;
                    if (timer_last) begin
                        timer_reg <= '0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    timer_reg <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line-level waveform model plus a byte scoreboard
// fed by a serial-line monitor. Works with or without UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;
    logic [4:0] level;

    int n_cmp = 0;
    int n_err = 0;
    int rst_epoch = 0;

    logic [7:0] exp_q[$];
    logic [8:0] rx_q[$];

    uart_tx_buffered #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .i_Clk   (clk),
        .i_Rst   (rst_n),
        .i_Valid (valid),
        .i_Data  (data),
        .o_Ready (ready),
        .o_Tx    (tx),
        .o_Busy  (busy),
        .o_Done  (done),
        .o_Level (level)
    );

    always #5 clk = ~clk;

    always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

    // Expected line level for bit slot idx of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic r;
        r = 1'b1;
        if (idx == 0) r = 1'b0;
        else if (idx <= 8) r = b[idx-1];
`ifdef UART_TX_PARITY_EN
        else if (idx == 9) r = ^b;
`endif
        return r;
    endfunction

    // Line monitor: decodes frames at mid-bit and pushes {frame_ok, byte}; frames cut by reset are dropped.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin : frame
                int         epoch;
                logic [7:0] b;
                logic       ok;
                epoch = rst_epoch;
                b = 8'h00;
                repeat (4) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (tx !== ^b) ok = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (epoch == rst_epoch) begin
                    rx_q.push_back({ok, b});
                    $display("line frame 0x%02h ok=%0d", b, ok);
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        $display("write 0x%02h ready=%0b level=%0d", b, ready, level);
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx, ready, busy, done, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_state got tx=%b rdy=%b busy=%b done=%b lvl=%0d want 1 1 0 0 0",
                     tx, ready, busy, done, level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx, ready, busy, done, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
                n_err++;
                $display("FAIL reset_idle k=%0d got tx=%b rdy=%b busy=%b done=%b lvl=%0d want 1 1 0 0 0",
                         k, tx, ready, busy, done, level);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       etx, ebusy, edone;
        logic [8:0] got;
        logic [7:0] want;
        int         t;
        b = 8'hA5;
        exp_q.push_back(b);
        write_byte(b);
        for (int k = 0; k <= FC + 2; k++) begin
            @(negedge clk);
            ebusy = (k >= 2 && k <= FC + 1);
            etx   = ebusy ? frame_bit(b, (k - 2) / CPB) : 1'b1;
            edone = (k == FC + 1);
            n_cmp++;
            if (tx !== etx) begin
                n_err++;
                $display("FAIL single_tx k=%0d got %b want %b", k, tx, etx);
            end
            n_cmp++;
            if (busy !== ebusy) begin
                n_err++;
                $display("FAIL single_busy k=%0d got %b want %b", k, busy, ebusy);
            end
            n_cmp++;
            if (done !== edone) begin
                n_err++;
                $display("FAIL single_done k=%0d got %b want %b", k, done, edone);
            end
        end
        t = 0;
        while (rx_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
        want = exp_q.pop_front();
        n_cmp++;
        if (rx_q.size() == 0) begin
            n_err++;
            $display("FAIL single_rx got no frame want 0x%02h", want);
        end else begin
            got = rx_q.pop_front();
            if (got !== {1'b1, want}) begin
                n_err++;
                $display("FAIL single_rx got ok=%b 0x%02h want ok=1 0x%02h", got[8], got[7:0], want);
            end
        end
    endtask

    task automatic test_burst();
        logic [8:0] got;
        logic [7:0] want;
        int         t;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            valid = 1'b1;
            data  = 8'(i);
            n_cmp++;
            if (ready !== 1'b1) begin
                n_err++;
                $display("FAIL burst_ready i=%0d got %b want 1", i, ready);
            end
            exp_q.push_back(8'(i));
            $display("write 0x%02h level=%0d", i, level);
            @(negedge clk);
        end
        n_cmp++;
        if (level !== 5'd16 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL burst_full got lvl=%0d rdy=%b want lvl=16 rdy=0", level, ready);
        end
        data = 8'h11;
        @(negedge clk);
        valid = 1'b0;
        n_cmp++;
        if (level !== 5'd16) begin
            n_err++;
            $display("FAIL burst_ignored got lvl=%0d want 16", level);
        end
        for (int i = 0; i < 17; i++) begin
            t = 0;
            while (rx_q.size() == 0 && t < 2 * FC + 50) begin @(negedge clk); t++; end
            want = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin
                n_err++;
                $display("FAIL burst_rx i=%0d got no frame want 0x%02h", i, want);
            end else begin
                got = rx_q.pop_front();
                if (got !== {1'b1, want}) begin
                    n_err++;
                    $display("FAIL burst_rx i=%0d got ok=%b 0x%02h want ok=1 0x%02h", i, got[8], got[7:0], want);
                end
            end
        end
        repeat (FC + 20) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 0 || level !== 5'd0) begin
            n_err++;
            $display("FAIL burst_extra got %0d extra frames lvl=%0d want 0 0", rx_q.size(), level);
            rx_q.delete();
        end
    endtask

    task automatic test_frame_length();
        logic [7:0] b;
        logic [8:0] got;
        logic [7:0] want;
        logic       slot9;
        int         s, t;
        b = 8'h07;
        exp_q.push_back(b);
        write_byte(b);
        t = 0;
        while (tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        s = 1;
        slot9 = 1'bx;
        while (done !== 1'b1 && s < FC + 40) begin
            @(negedge clk);
            s++;
            if (s == 9 * CPB + 5) slot9 = tx;
        end
        n_cmp++;
        if (s != FC) begin
            n_err++;
            $display("FAIL frame_len got %0d clocks want %0d", s, FC);
        end
        n_cmp++;
        if (slot9 !== frame_bit(b, 9)) begin
            n_err++;
            $display("FAIL frame_slot9 got %b want %b", slot9, frame_bit(b, 9));
        end
        t = 0;
        while (rx_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
        want = exp_q.pop_front();
        n_cmp++;
        if (rx_q.size() == 0) begin
            n_err++;
            $display("FAIL frame_rx got no frame want 0x%02h", want);
        end else begin
            got = rx_q.pop_front();
            if (got !== {1'b1, want}) begin
                n_err++;
                $display("FAIL frame_rx got ok=%b 0x%02h want ok=1 0x%02h", got[8], got[7:0], want);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t;
        write_byte(8'h3C);
        write_byte(8'h11);
        t = 0;
        while (tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        repeat (44) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || level !== 5'd1) begin
            n_err++;
            $display("FAIL midframe_pre got busy=%b lvl=%0d want 1 1", busy, level);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx, ready, busy, done, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL midframe_rst got tx=%b rdy=%b busy=%b done=%b lvl=%0d want 1 1 0 0 0",
                     tx, ready, busy, done, level);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b0 || level !== 5'd0) begin
                n_err++;
                $display("FAIL midframe_idle k=%0d got tx=%b busy=%b lvl=%0d want 1 0 0", k, tx, busy, level);
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin
            n_err++;
            $display("FAIL midframe_rx got %0d frames want 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        logic       etx, ebusy, edone;
        logic [8:0] got;
        logic [7:0] want;
        int         t;
        b0 = 8'h55;
        b1 = 8'hAA;
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        write_byte(b0);
        write_byte(b1);
        for (int k = 1; k <= 2 * FC + 4; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= FC + 1) begin
                etx = frame_bit(b0, (k - 2) / CPB); ebusy = 1'b1;
            end else if (k >= FC + 3 && k <= 2 * FC + 2) begin
                etx = frame_bit(b1, (k - FC - 3) / CPB); ebusy = 1'b1;
            end else begin
                etx = 1'b1; ebusy = 1'b0;
            end
            edone = (k == FC + 1) || (k == 2 * FC + 2);
            n_cmp++;
            if (tx !== etx || busy !== ebusy || done !== edone) begin
                n_err++;
                $display("FAIL b2b k=%0d got tx=%b busy=%b done=%b want %b %b %b",
                         k, tx, busy, done, etx, ebusy, edone);
            end
        end
        for (int i = 0; i < 2; i++) begin
            t = 0;
            while (rx_q.size() == 0 && t < 200) begin @(negedge clk); t++; end
            want = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin
                n_err++;
                $display("FAIL b2b_rx i=%0d got no frame want 0x%02h", i, want);
            end else begin
                got = rx_q.pop_front();
                if (got !== {1'b1, want}) begin
                    n_err++;
                    $display("FAIL b2b_rx i=%0d got ok=%b 0x%02h want ok=1 0x%02h", i, got[8], got[7:0], want);
                end
            end
        end
    endtask

    initial begin : watchdog
        #400_000;
        $display("FAIL watchdog got timeout want completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_single_frame();
        repeat (20) @(negedge clk);
        test_burst();
        test_frame_length();
        repeat (20) @(negedge clk);
        test_reset_midframe();
        test_back_to_back();
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
